// File: rtl/mem_wb_stage.sv
// MIPS memory-access stage fused with the MEM/WB pipeline register.
// Issues byte/half/word loads and stores over a req/ack port, stalling while an access is outstanding.
module mem_wb_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [1:0]  wb_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        stall,
    output logic [31:0] datafrommem,
    output logic [31:0] datafromimm,
    output logic [1:0]  wb,
    output logic        misalign,
    output logic        timeout_err
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [31:0] l_addr, l_data;
    logic [1:0]  l_size, l_wb;
    logic        l_sext, l_write;

    logic        op_active, misaligned, in_wait, last;
    logic [31:0] e_addr, e_data, load_val;
    logic [1:0]  e_size, e_wb;
    logic        e_sext, e_write;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // In WAIT the request is replayed from the latched copy, not the (frozen) inputs.
    always_comb begin
        in_wait    = (state == S_WAIT);
        op_active  = mem_read | mem_write;
        misaligned = op_active && (((size == 2'b01) && alu_result[0]) ||
                                   (size[1] && (alu_result[1:0] != 2'b00)));
        e_addr  = in_wait ? l_addr  : alu_result;
        e_data  = in_wait ? l_data  : store_data;
        e_size  = in_wait ? l_size  : size;
        e_wb    = in_wait ? l_wb    : wb_in;
        e_sext  = in_wait ? l_sext  : sign_ext;
        e_write = in_wait ? l_write : mem_write;
        last     = in_wait && (cnt == LAST);
        dmem_req = ~reset & (in_wait | (op_active & ~misaligned));
        stall    = dmem_req & ~dmem_ack & ~last;
    end

    always_comb begin
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_be    = '0;
        dmem_we    = 1'b0;
        if (dmem_req) begin
            dmem_addr = {e_addr[31:2], 2'b00};
            dmem_we   = e_write;
            dmem_be   = 4'b1111;
            if (e_write) begin
                case (e_size)
                    2'b00: begin
                        dmem_wdata = {4{e_data[7:0]}};
                        dmem_be    = 4'b0001 << e_addr[1:0];
                    end
                    2'b01: begin
                        dmem_wdata = {2{e_data[15:0]}};
                        dmem_be    = e_addr[1] ? 4'b1100 : 4'b0011;
                    end
                    default: dmem_wdata = e_data;
                endcase
            end
        end
    end

    always_comb begin
        byte_sel = dmem_rdata[{e_addr[1:0], 3'b000} +: 8];
        half_sel = dmem_rdata[{e_addr[1], 4'b0000} +: 16];
        case (e_size)
            2'b00:   load_val = {{24{e_sext & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{e_sext & half_sel[15]}}, half_sel};
            default: load_val = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            l_addr      <= '0;
            l_data      <= '0;
            l_size      <= '0;
            l_wb        <= '0;
            l_sext      <= 1'b0;
            l_write     <= 1'b0;
            datafrommem <= '0;
            datafromimm <= '0;
            wb          <= '0;
            misalign    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            misalign    <= 1'b0;
            timeout_err <= 1'b0;
            if (dmem_req && dmem_ack) begin
                datafrommem <= e_write ? '0 : load_val;
                datafromimm <= e_addr;
                wb          <= e_wb;
                state       <= S_IDLE;
                cnt         <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        datafromimm <= alu_result;
                        datafrommem <= '0;
                        if (!op_active) begin
                            wb <= wb_in;
                        end else if (misaligned) begin
                            wb       <= 2'b00;
                            misalign <= 1'b1;
                        end else begin
                            wb      <= 2'b00;
                            l_addr  <= alu_result;
                            l_data  <= store_data;
                            l_size  <= size;
                            l_wb    <= wb_in;
                            l_sext  <= sign_ext;
                            l_write <= mem_write;
                            cnt     <= '0;
                            state   <= S_WAIT;
                        end
                    end
                    default: begin
                        datafromimm <= l_addr;
                        datafrommem <= '0;
                        wb          <= 2'b00;
                        if (last) begin
                            timeout_err <= 1'b1;
                            cnt         <= '0;
                            state       <= S_IDLE;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected register contents are queued at issue and
// compared when the stage releases the instruction.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result, store_data, dmem_rdata;
    logic [1:0]  wb_in, size;
    logic        mem_read, mem_write, sign_ext, dmem_ack;
    logic        dmem_req, dmem_we, stall, misalign, timeout_err;
    logic [31:0] dmem_addr, dmem_wdata, datafrommem, datafromimm;
    logic [3:0]  dmem_be;
    logic [1:0]  wb;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] addr, data, rdata;
        logic [1:0]  wbin, sz;
        logic        rd, wr, sx;
        int          ack_delay;
        int          stalls;
        logic        e_req, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic [31:0] x_mem, x_imm;
        logic [1:0]  x_wb;
        logic        x_mis, x_tmo, ck_mem, ck_imm;
    } op_t;

    typedef struct {
        logic [31:0] mem, imm;
        logic [1:0]  wb;
        logic        mis, tmo, ck_mem, ck_imm;
    } exp_t;

    exp_t sb[$];

    mem_wb_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .store_data(store_data),
        .wb_in(wb_in), .mem_read(mem_read), .mem_write(mem_write), .size(size),
        .sign_ext(sign_ext), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .stall(stall),
        .datafrommem(datafrommem), .datafromimm(datafromimm), .wb(wb),
        .misalign(misalign), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic drive_idle();
        alu_result = '0; store_data = '0; wb_in = '0; mem_read = 1'b0; mem_write = 1'b0;
        size = '0; sign_ext = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic run_op(input string name, input op_t o);
        exp_t e;
        int   stalls;
        bit   done;
        sb.push_back('{mem: o.x_mem, imm: o.x_imm, wb: o.x_wb, mis: o.x_mis, tmo: o.x_tmo,
                       ck_mem: o.ck_mem, ck_imm: o.ck_imm});
        @(negedge clk);
        alu_result = o.addr; store_data = o.data; wb_in = o.wbin; mem_read = o.rd;
        mem_write = o.wr; size = o.sz; sign_ext = o.sx;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ack   = (c == o.ack_delay);
            dmem_rdata = dmem_ack ? o.rdata : 32'h0;
            #1;
            check({name, ".req"}, 32'(dmem_req), 32'(o.e_req));
            if (c == 0 && o.e_req) begin
                check({name, ".addr"}, dmem_addr, o.e_addr);
                check({name, ".we"}, 32'(dmem_we), 32'(o.e_we));
                check({name, ".be"}, 32'(dmem_be), 32'(o.e_be));
                if (o.e_we) check({name, ".wdata"}, dmem_wdata, o.e_wdata);
            end
            if (stall) stalls++;
            done = !stall;
            @(posedge clk);
            #1;
            if (!done) check({name, ".bubble_wb"}, 32'(wb), 32'h0);
        end
        if (!done) check({name, ".bound"}, 32'h0, 32'h1);
        check({name, ".stall_cycles"}, 32'(stalls), 32'(o.stalls));
        e = sb.pop_front();
        if (e.ck_mem) check({name, ".datafrommem"}, datafrommem, e.mem);
        if (e.ck_imm) check({name, ".datafromimm"}, datafromimm, e.imm);
        check({name, ".wb"}, 32'(wb), 32'(e.wb));
        check({name, ".misalign"}, 32'(misalign), 32'(e.mis));
        check({name, ".timeout_err"}, 32'(timeout_err), 32'(e.tmo));
        @(negedge clk);
        drive_idle();
        #1;
        check({name, ".req_drop"}, 32'(dmem_req), 32'h0);
        @(posedge clk);
        #1;
        check({name, ".pulse_clear"}, 32'({misalign, timeout_err}), 32'h0);
    endtask

    initial begin
        op_t o;
        drive_idle();
        reset = 1'b1;
        #2;
        check("reset.regs", datafrommem | datafromimm, 32'h0);
        check("reset.ctl", 32'({wb, misalign, timeout_err, dmem_req, stall}), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        o = '{addr: 32'h10, wbin: 2'b10, x_imm: 32'h10, x_wb: 2'b10, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("alu", o);

        o = '{addr: 32'h103, sx: 1, rd: 1, wbin: 2'b11, rdata: 32'h80FF_FFFF, e_req: 1,
              e_addr: 32'h100, e_be: 4'b1111, x_mem: 32'hFFFF_FF80, x_imm: 32'h103,
              x_wb: 2'b11, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("lb_imm", o);

        o = '{addr: 32'h202, sz: 2'b01, rd: 1, wbin: 2'b11, rdata: 32'hBEEF_1234, ack_delay: 3,
              stalls: 3, e_req: 1, e_addr: 32'h200, e_be: 4'b1111, x_mem: 32'h0000_BEEF,
              x_imm: 32'h202, x_wb: 2'b11, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("lhu_wait", o);

        o = '{addr: 32'h301, data: 32'hAB, wr: 1, e_req: 1, e_we: 1, e_addr: 32'h300,
              e_be: 4'b0010, e_wdata: 32'hABAB_ABAB, x_imm: 32'h301, ck_imm: 1, default: 0};
        run_op("sb", o);

        o = '{addr: 32'h502, data: 32'h1234_CDEF, sz: 2'b01, wr: 1, ack_delay: 1, stalls: 1,
              e_req: 1, e_we: 1, e_addr: 32'h500, e_be: 4'b1100, e_wdata: 32'hCDEF_CDEF,
              x_imm: 32'h502, ck_imm: 1, default: 0};
        run_op("sh_hi", o);

        o = '{addr: 32'h604, data: 32'hDEAD_BEEF, sz: 2'b11, rd: 1, wr: 1, e_req: 1, e_we: 1,
              e_addr: 32'h604, e_be: 4'b1111, e_wdata: 32'hDEAD_BEEF, x_imm: 32'h604,
              ck_imm: 1, default: 0};
        run_op("sw_rdwr", o);

        o = '{addr: 32'h701, rd: 1, wbin: 2'b11, rdata: 32'h0000_F100, ack_delay: 2, stalls: 2,
              e_req: 1, e_addr: 32'h700, e_be: 4'b1111, x_mem: 32'h0000_00F1, x_imm: 32'h701,
              x_wb: 2'b11, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("lbu", o);

        o = '{addr: 32'h800, sz: 2'b01, sx: 1, rd: 1, wbin: 2'b11, rdata: 32'h0000_8001,
              e_req: 1, e_addr: 32'h800, e_be: 4'b1111, x_mem: 32'hFFFF_8001, x_imm: 32'h800,
              x_wb: 2'b11, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("lh_sext", o);

        o = '{addr: 32'h402, sz: 2'b10, rd: 1, wbin: 2'b11, x_imm: 32'h402, x_mis: 1,
              ck_mem: 1, ck_imm: 1, default: 0};
        run_op("lw_misalign", o);

        o = '{addr: 32'h203, sz: 2'b01, wr: 1, data: 32'h55, x_imm: 32'h203, x_mis: 1,
              ck_mem: 1, ck_imm: 1, default: 0};
        run_op("sh_misalign", o);

        o = '{addr: 32'h900, sz: 2'b10, rd: 1, wbin: 2'b11, ack_delay: -1, stalls: 4, e_req: 1,
              e_addr: 32'h900, e_be: 4'b1111, x_tmo: 1, default: 0};
        run_op("timeout", o);

        o = '{addr: 32'hA00, sz: 2'b10, rd: 1, wbin: 2'b11, rdata: 32'h1122_3344, ack_delay: 4,
              stalls: 4, e_req: 1, e_addr: 32'hA00, e_be: 4'b1111, x_mem: 32'h1122_3344,
              x_imm: 32'hA00, x_wb: 2'b11, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("ack_at_limit", o);

        // Reset during the second WAIT cycle of a load that is never acknowledged.
        @(negedge clk);
        alu_result = 32'hB00; size = 2'b10; mem_read = 1'b1; wb_in = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        check("rst_wait.pre_stall", 32'(stall), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_wait.req", 32'(dmem_req), 32'h0);
        check("rst_wait.stall", 32'(stall), 32'h0);
        check("rst_wait.regs", datafrommem | datafromimm, 32'h0);
        check("rst_wait.ctl", 32'({wb, misalign, timeout_err}), 32'h0);
        @(negedge clk);
        drive_idle();
        reset = 1'b0;

        o = '{addr: 32'h55, wbin: 2'b10, x_imm: 32'h55, x_wb: 2'b10, ck_mem: 1, ck_imm: 1, default: 0};
        run_op("alu_after_rst", o);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
